// File: rtl/fp_cikarma_if.sv
// fp_cikarma_if: start/operand/result bundle for fp_cikarma; master drives en_i/g1_i/g2_i, slave returns fark_o/gecerli_o/mesgul_o
interface fp_cikarma_if #(parameter int b = 32);
  logic en_i;
  logic [b-1:0] g1_i;
  logic [b-1:0] g2_i;
  logic [b-1:0] fark_o;
  logic gecerli_o;
  logic mesgul_o;
  modport master(output en_i, g1_i, g2_i, input fark_o, gecerli_o, mesgul_o);
  modport slave(input en_i, g1_i, g2_i, output fark_o, gecerli_o, mesgul_o);
endinterface

// File: rtl/fp_cikarma.sv
// fp_cikarma: multi-cycle IEEE-754 subtractor fark_o = g1_i - g2_i; ports clk_i, rst_i, bus (fp_cikarma_if.slave); FP_CIKARMA_RNE_EN selects RNE, else truncate
module fp_cikarma #(
  parameter int b = 32,
  parameter int e = 8,
  parameter int m = 23
) (
  input logic clk_i,
  input logic rst_i,
  fp_cikarma_if.slave bus
);
  localparam int w = m + 5;
  localparam logic signed [e+1:0] emax = (e+2)'((1 << e) - 1);
  typedef enum logic [2:0] {IDLE, HIZALA, ISLEM, NORMAL, YUVARLA} state_t;
  state_t st, st_n;
  logic [b-1:0] a_r, b_r, fark, spec_v, x, y, res;
  logic [w-1:0] ma, mb, xm, ym, ys;
  logic [e-1:0] e1, e2, d;
  logic signed [e+1:0] ex, ef;
  logic [m+1:0] rn;
  logic [m-1:0] fr;
  logic sg, sub, zero, gecerli, nan, z1, z2, spec, swap, up, ovf;
  assign e1 = bus.g1_i[b-2:m];
  assign e2 = bus.g2_i[b-2:m];
  assign nan = &e1 | &e2;
  assign z1 = ~|e1;
  assign z2 = ~|e2;
  assign spec = nan | z1 | z2;
  assign bus.fark_o = fark;
  assign bus.gecerli_o = gecerli;
  assign bus.mesgul_o = st != IDLE;
  always_comb begin
    spec_v = nan ? {1'b0, {e{1'b1}}, 1'b1, {(m-1){1'b0}}} :
             (z1 & z2) ? '0 :
             z1 ? {~bus.g2_i[b-1], bus.g2_i[b-2:0]} : bus.g1_i;
    swap = b_r[b-2:0] > a_r[b-2:0];
    x = swap ? b_r : a_r;
    y = swap ? a_r : b_r;
    xm = {2'b01, x[m-1:0], 3'b000};
    ym = {2'b01, y[m-1:0], 3'b000};
    d = x[b-2:m] - y[b-2:m];
    ys = (int'(d) >= m + 3) ? w'(1) :
         ((ym >> d) | w'(|(ym & ~({w{1'b1}} << d))));
`ifdef FP_CIKARMA_RNE_EN
    up = ma[2] & (ma[1] | ma[0] | ma[3]);
`else
    up = 1'b0;
`endif
    rn = {1'b0, ma[m+3:3]} + (m+2)'(up);
    ovf = rn[m+1];
    fr = ovf ? rn[m:1] : rn[m-1:0];
    ef = ex + {{(e+1){1'b0}}, ovf};
    res = (zero || ef <= 0) ? '0 :
          (ef >= emax) ? {sg, {e{1'b1}}, {m{1'b0}}} : {sg, ef[e-1:0], fr};
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = (bus.en_i && !spec) ? HIZALA : IDLE;
      HIZALA:  st_n = ISLEM;
      ISLEM:   st_n = NORMAL;
      NORMAL:  st_n = (ma == '0 || ma[w-1] || ma[w-2]) ? YUVARLA : NORMAL;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    gecerli <= 1'b0;
    case (st)
      IDLE: if (bus.en_i) begin
        a_r <= bus.g1_i;
        b_r <= {~bus.g2_i[b-1], bus.g2_i[b-2:0]};
        zero <= 1'b0;
        if (spec) begin
          fark <= spec_v;
          gecerli <= 1'b1;
        end
      end
      HIZALA: begin
        ma <= xm;
        mb <= ys;
        ex <= {2'b00, x[b-2:m]};
        sg <= x[b-1];
        sub <= x[b-1] ^ y[b-1];
      end
      ISLEM: ma <= sub ? ma - mb : ma + mb;
      NORMAL: if (ma == '0) zero <= 1'b1;
        else if (ma[w-1]) begin
          ma <= {1'b0, ma[w-1:2], ma[1] | ma[0]};
          ex <= ex + 1'b1;
        end else if (!ma[w-2]) begin
          ma <= ma << 1;
          ex <= ex - 1'b1;
        end
      YUVARLA: begin
        fark <= res;
        gecerli <= 1'b1;
      end
      default: ;
    endcase
    st <= st_n;
    if (rst_i) begin
      st <= IDLE;
      fark <= '0;
      gecerli <= 1'b0;
    end
  end
endmodule
